// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// feeds decode through a one-entry skid buffer. Define FETCH_PERF_EN for counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] new_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_out,
  output logic [15:0] pcp2_out,
  output logic [15:0] ir_out,
  output logic        valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] squash_cnt
`endif
);

  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        infl_v_q, infl_v_d;
  logic [15:0] infl_pc_q, infl_pc_d;
  logic        hold_v_q, hold_v_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic [15:0] hold_ir_q, hold_ir_d;
  logic [15:0] last_pc_q, last_pc_d;

  logic        slot_v;
  logic [15:0] slot_pc;
  logic [15:0] slot_ir;
  logic [15:0] jump_tgt;

  assign jump_tgt = new_pc & 16'hFFFE;

  // Output slot: skid buffer wins over the in-flight read; an empty slot
  // keeps reporting the last presented pc so decode sees a stable value.
  always_comb begin
    slot_v  = hold_v_q | infl_v_q;
    slot_pc = last_pc_q;
    slot_ir = NOP_INSTR;
    if (hold_v_q) begin
      slot_pc = hold_pc_q;
      slot_ir = hold_ir_q;
    end else if (infl_v_q) begin
      slot_pc = infl_pc_q;
      slot_ir = imem_data;
    end

    if (reset) begin
      valid_out = 1'b0;
      pc_out    = RESET_PC;
      ir_out    = NOP_INSTR;
    end else begin
      valid_out = slot_v & ~jump;
      pc_out    = slot_pc;
      ir_out    = (slot_v && !jump) ? slot_ir : NOP_INSTR;
    end
    pcp2_out = pc_out + 16'd2;
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    imem_rd    = 1'b0;
    imem_addr  = fetch_pc_q;
    fetch_pc_d = fetch_pc_q;
    infl_v_d   = infl_v_q;
    infl_pc_d  = infl_pc_q;
    hold_v_d   = hold_v_q;
    hold_pc_d  = hold_pc_q;
    hold_ir_d  = hold_ir_q;
    last_pc_d  = slot_pc;

    if (reset) begin
      imem_rd = 1'b0;
    end else if (jump) begin
      imem_rd    = 1'b1;
      imem_addr  = jump_tgt;
      fetch_pc_d = jump_tgt + 16'd2;
      infl_v_d   = 1'b1;
      infl_pc_d  = jump_tgt;
      hold_v_d   = 1'b0;
    end else if (stall) begin
      infl_v_d = 1'b0;
      if (!hold_v_q && infl_v_q) begin
        hold_v_d  = 1'b1;
        hold_pc_d = infl_pc_q;
        hold_ir_d = imem_data;
      end
    end else begin
      imem_rd    = 1'b1;
      imem_addr  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 16'd2;
      infl_v_d   = 1'b1;
      infl_pc_d  = fetch_pc_q;
      hold_v_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      infl_v_q   <= 1'b0;
      hold_v_q   <= 1'b0;
      last_pc_q  <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_v_q   <= infl_v_d;
      hold_v_q   <= hold_v_d;
      last_pc_q  <= last_pc_d;
    end
  end

  // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
    hold_pc_q <= hold_pc_d;
    hold_ir_q <= hold_ir_d;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;
  logic        squash_ev;

  always_comb begin
    squash_ev    = ~reset & jump & slot_v;
    fetch_cnt_d  = fetch_cnt_q + {15'd0, imem_rd};
    squash_cnt_d = squash_cnt_q + {15'd0, squash_ev};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 16'd0;
      squash_cnt_q <= 16'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: consumed instructions are matched
// against a queue of expected pcs; cycle-specific behaviour is checked directly.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] new_pc = 16'h0000;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] pc_out;
  logic [15:0] pcp2_out;
  logic [15:0] ir_out;
  logic        valid_out;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] exp_q[$];

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump      (jump),
    .new_pc    (new_pc),
    .imem_rd   (imem_rd),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc_out    (pc_out),
    .pcp2_out  (pcp2_out),
    .ir_out    (ir_out),
    .valid_out (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address A holds A ^ 16'hA5A5.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= imem_addr ^ 16'hA5A5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_q.push_back(pc);
  endtask

  // An instruction is consumed when it is valid and decode is not stalled.
  task automatic monitor();
    logic [15:0] e;
    if (!reset && valid_out && !stall) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", {16'h0, pc_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc",   {16'h0, pc_out},   {16'h0, e});
        check("sb_pcp2", {16'h0, pcp2_out}, {16'h0, 16'(e + 16'd2)});
        check("sb_ir",   {16'h0, ir_out},   {16'h0, e ^ 16'hA5A5});
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge, let outputs settle, score.
  task automatic cyc(input logic r, input logic s, input logic j, input logic [15:0] np);
    @(negedge clk);
    reset  = r;
    stall  = s;
    jump   = j;
    new_pc = np;
    #1;
    monitor();
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_rd",    {31'h0, imem_rd},   32'h0);
    check("rst_pc",    {16'h0, pc_out},    32'h0000);
    check("rst_pcp2",  {16'h0, pcp2_out},  32'h0002);
    check("rst_ir",    {16'h0, ir_out},    32'h0000);

    // Reset release and streaming
    push(16'h0000); push(16'h0002); push(16'h0004);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("first_rd",    {31'h0, imem_rd},  32'h1);
    check("first_addr",  {16'h0, imem_addr}, 32'h0000);
    check("first_valid", {31'h0, valid_out}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("c2_valid", {31'h0, valid_out}, 32'h1);
    check("c2_addr",  {16'h0, imem_addr}, 32'h0002);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("c3_addr",  {16'h0, imem_addr}, 32'h0004);

    // Three-cycle stall while presenting 0x0004
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      check("stall_pc",    {16'h0, pc_out},    32'h0004);
      check("stall_ir",    {16'h0, ir_out},    {16'h0, 16'h0004 ^ 16'hA5A5});
      check("stall_valid", {31'h0, valid_out}, 32'h1);
      check("stall_rd",    {31'h0, imem_rd},   32'h0);
    end
    push(16'h0006); push(16'h0008); push(16'h000A); push(16'h000C); push(16'h000E);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("unstall_addr", {16'h0, imem_addr}, 32'h0006);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Jump to 0x0041 while presenting 0x0010
    check("prejump_pc", {16'h0, pc_out}, 32'h000E);
    push(16'h0040); push(16'h0042);
    cyc(1'b0, 1'b0, 1'b1, 16'h0041);
    check("jump_valid", {31'h0, valid_out}, 32'h0);
    check("jump_ir",    {16'h0, ir_out},    32'h0000);
    check("jump_rd",    {31'h0, imem_rd},   32'h1);
    check("jump_addr",  {16'h0, imem_addr}, 32'h0040);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Fill the skid buffer, then jump and stall together
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    check("hold_pc", {16'h0, pc_out}, 32'h0044);
    push(16'h0100);
    cyc(1'b0, 1'b1, 1'b1, 16'h0100);
    check("js_valid", {31'h0, valid_out}, 32'h0);
    check("js_addr",  {16'h0, imem_addr}, 32'h0100);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Jump to the top of the address space
    push(16'hFFFE); push(16'h0000); push(16'h0002);
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFE);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_pcp2", {16'h0, pcp2_out}, 32'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Back-to-back jumps: only the last target is presented
    push(16'h0300);
    cyc(1'b0, 1'b0, 1'b1, 16'h0200);
    cyc(1'b0, 1'b0, 1'b1, 16'h0300);
    check("b2b_valid", {31'h0, valid_out}, 32'h0);
    check("b2b_addr",  {16'h0, imem_addr}, 32'h0300);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Reset during a two-cycle stall
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    check("pre_rst_hold", {16'h0, pc_out}, 32'h0302);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    check("mid_rst_rd", {31'h0, imem_rd}, 32'h0);
    push(16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("post_rst_valid", {31'h0, valid_out}, 32'h0);
    check("post_rst_pc",    {16'h0, pc_out},    32'h0000);
    check("post_rst_addr",  {16'h0, imem_addr}, 32'h0000);
`ifdef FETCH_PERF_EN
    check("post_rst_fetch_cnt",  {16'h0, fetch_cnt},  32'h0);
    check("post_rst_squash_cnt", {16'h0, squash_cnt}, 32'h0);
`endif
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);

    check("sb_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Owns the program counter and issues reads to a synchronous instruction memory with 1-cycle latency.
- Presents pc, pc+2 and the instruction word to the decode stage's IF/ID inputs (pc_in, IPCP2, ir_in).
- Honours the stall from hazard logic and the jump redirect (new_pc, jump) produced by decode. Squashes wrong-path fetches by emitting a NOP bubble.

Parameters:
- RESET_PC, 16'h0000, first instruction address after reset.
- NOP_INSTR, 16'h0000, instruction word driven when the output slot is invalid.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold the current output slot.
- jump  input  1  redirect request from decode, sampled each cycle.
- new_pc  input  16  redirect target; bit 0 is forced to 0.
- imem_rd  output  1  instruction-memory read strobe.
- imem_addr  output  16  instruction-memory word address (byte address, even).
- imem_data  input  16  read data, valid the cycle after imem_rd.
- pc_out  output  16  pc of the presented instruction; drives decode pc_in.
- pcp2_out  output  16  pc_out+2 mod 2^16; drives decode IPCP2.
- ir_out  output  16  presented instruction; drives decode ir_in.
- valid_out  output  1  output slot holds a real instruction.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- State:
  - fetch_pc[15:0]: next address to issue.
  - infl_v, infl_pc: a read was issued last cycle.
  - hold_v, hold_pc, hold_ir: skid buffer, one entry.
- Reset (reset=1 at an edge): fetch_pc=RESET_PC, infl_v=0, hold_v=0. During the reset cycle imem_rd=0.
- Outputs while in reset / empty: valid_out=0, ir_out=NOP_INSTR, pc_out=RESET_PC, pcp2_out=RESET_PC+2.
- Output slot selection (combinational):
  - If hold_v: present hold_pc/hold_ir.
  - Else if infl_v: present infl_pc/imem_data.
  - Else empty: valid_out=0, ir_out=NOP_INSTR, pc fields keep the last registered slot pc.
  - pcp2_out = pc_out+2, truncated to 16 bits (0xFFFE -> 0x0000).
- Priority each cycle: reset > jump > stall > normal.
- Normal (jump=0, stall=0):
  - imem_rd=1, imem_addr=fetch_pc.
  - fetch_pc<=fetch_pc+2, wrapping 0xFFFE->0x0000.
  - infl_v<=1, infl_pc<=fetch_pc, hold_v<=0.
  - Decode consumes the presented slot at this edge.
- Stall (jump=0, stall=1):
  - imem_rd=0, fetch_pc holds, infl_v<=0.
  - If the slot is supplied by infl: capture into hold (hold_v<=1, hold_pc<=infl_pc, hold_ir<=imem_data).
  - If hold_v is already set: hold is unchanged.
  - Outputs are stable for the whole stall. Multi-cycle stalls lose no instruction and duplicate none.
- Jump (jump=1, regardless of stall):
  - Current slot is squashed: valid_out=0 and ir_out=NOP_INSTR this cycle.
  - imem_rd=1, imem_addr={new_pc[15:1],1'b0}.
  - fetch_pc<=target+2, infl_v<=1, infl_pc<=target, hold_v<=0.
  - The target instruction is presented the next cycle with valid_out=1.
- Latency:
  - Reset release to first valid_out: 1 cycle after the first issue, i.e. the second cycle out of reset.
  - Jump to target valid: 1 cycle.
- Steady state: one instruction per cycle with no stall or jump.
- Stall dropping: the held instruction is presented in the same cycle as the next issue, then continues in sequence.
- Reset asserted mid-stall or during a jump: all state is cleared; no held instruction survives.
- Back-to-back jumps: each jump squashes the previous target's slot; only the last target is presented.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports fetch_cnt[15:0] and squash_cnt[15:0].
  - fetch_cnt increments on every cycle with imem_rd=1.
  - squash_cnt increments on every jump cycle in which the slot would otherwise have been valid.
  - Both wrap at 2^16 and reset to 0.
- Not defined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset release, no stall/jump, memory word at addr A = A^16'hA5A5:
  - imem_addr 0x0000, 0x0002, 0x0004...
  - valid_out rises on cycle 2 with pc_out=0x0000, pcp2_out=0x0002, ir_out=0xA5A5.
  - One instruction per cycle thereafter.
- Stall for 3 cycles while presenting pc=0x0004:
  - Outputs frozen at 0x0004 / mem[4]; imem_rd=0.
  - After release: 0x0004 once more, then 0x0006, 0x0008. No gap, no duplicate.
- jump=1, new_pc=0x0041 while presenting 0x0010:
  - Same cycle: valid_out=0, ir_out=0x0000, imem_addr=0x0040.
  - Next cycle: pc_out=0x0040 valid; then 0x0042.
- jump and stall asserted together, new_pc=0x0100:
  - Jump wins; hold cleared; pc_out=0x0100 next cycle.
- jump to 0xFFFE:
  - Presents pc 0xFFFE with pcp2_out=0x0000, then pc 0x0000.
- reset asserted during a 2-cycle stall:
  - Next cycle valid_out=0, pc_out=RESET_PC. Held instruction never reappears.
  - With FETCH_PERF_EN: counters read 0.
